cdb_starve_guard: RTL and testbench

Anti-starvation controller that sits between the functional-unit request lines and the CDB arbiter's request input. The CDB arbiter grants in fixed priority order (branch, ALU, mem, mult), so a low-priority unit can wait indefinitely under sustained high-priority traffic. This block counts how long each requester has waited without a grant. When one reaches a limit, it masks every higher-priority request until the starved requester is granted, then enforces a cooldown. It is purely a request filter: it never changes grants, payloads or tags.

---
 rtl/cdb_starve_guard_pkg.sv | 31 +++
 rtl/cdb_wait_counter.sv | 38 +++
 rtl/cdb_starve_guard.sv | 157 +++++++++++++++
 tb/tb_cdb_starve_guard.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/cdb_starve_guard_pkg.sv
// Shared definitions for the CDB anti-starvation guard: FSM state type,
// default limits and the flat requester priority order used by the CDB arbiter.
package cdb_starve_guard_pkg;

  // Flat requester layout, highest priority first (index 0).
  localparam int NUM_BRANCH_FU = 1;
  localparam int NUM_ALU_FU    = 2;
  localparam int NUM_MEM_FU    = 1;
  localparam int NUM_MULT_FU   = 2;
  localparam int NUM_FU_TOTAL  = NUM_BRANCH_FU + NUM_ALU_FU + NUM_MEM_FU + NUM_MULT_FU;

  localparam int CDB_PRIO_BRANCH_BASE = 0;
  localparam int CDB_PRIO_ALU_BASE    = CDB_PRIO_BRANCH_BASE + NUM_BRANCH_FU;
  localparam int CDB_PRIO_MEM_BASE    = CDB_PRIO_ALU_BASE + NUM_ALU_FU;
  localparam int CDB_PRIO_MULT_BASE   = CDB_PRIO_MEM_BASE + NUM_MEM_FU;

  // Default guard tuning.
  localparam int CDB_STARVE_LIMIT   = 8;
  localparam int CDB_GUARD_COOLDOWN = 2;

  // state    | meaning
  // NORMAL   | requests pass through, watching for a saturated wait counter
  // BOOST    | requests above the victim are masked until it is served
  // COOLDOWN | pass-through, no new boost until the cooldown count expires
  typedef enum logic [1:0] {
    NORMAL   = 2'd0,
    BOOST    = 2'd1,
    COOLDOWN = 2'd2
  } CDB_GUARD_STATE;

endpackage

// File: rtl/cdb_wait_counter.sv
// Saturating per-requester wait counter. clr wins over inc; sat flags that
// the count has reached LIMIT and holds there until cleared.
module cdb_wait_counter #(
  parameter int LIMIT = 8,
  parameter int W     = $clog2(LIMIT + 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign sat = (count_q == LIMIT[W-1:0]);

  // Next count: clear, increment, or hold once saturated.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && !sat) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/cdb_starve_guard.sv
// Anti-starvation request filter in front of the fixed-priority CDB arbiter.
// Counts ungranted request cycles per requester; when one saturates, every
// higher-priority request is masked until that requester is served, then a
// cooldown blocks the next boost. Grants, payloads and tags are untouched.
// Optional build macro CDB_STARVE_STATS_EN adds boost statistics outputs
// (boost_count, boost_cycles), cleared by reset only.
module cdb_starve_guard
  import cdb_starve_guard_pkg::*;
#(
  parameter  int NUM_REQ         = NUM_FU_TOTAL,
  parameter  int STARVE_LIMIT    = CDB_STARVE_LIMIT,
  parameter  int COOLDOWN_CYCLES = CDB_GUARD_COOLDOWN,
  localparam int VW              = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_in,
  input  logic [NUM_REQ-1:0] gnt_in,
  input  logic               squash,
  output logic [NUM_REQ-1:0] req_out,
  output logic               boost_active,
  output logic [VW-1:0]      boost_victim
`ifdef CDB_STARVE_STATS_EN
  ,
  output logic [NUM_REQ-1:0][15:0] boost_count,
  output logic [31:0]              boost_cycles
`endif
);

  localparam logic [3:0] COOL_INIT = COOLDOWN_CYCLES[3:0];

  CDB_GUARD_STATE     state_q, state_d;
  logic [VW-1:0]      victim_q, victim_d;
  logic [3:0]         cool_q, cool_d;
  logic [NUM_REQ-1:0] sat;
  logic               any_sat;
  logic [VW-1:0]      sat_idx;
  logic [NUM_REQ-1:0] keep;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_wait
    cdb_wait_counter #(
      .LIMIT(STARVE_LIMIT)
    ) u_wait (
      .clock(clock),
      .reset(reset),
      .inc  (req_in[gi] & ~gnt_in[gi]),
      .clr  (gnt_in[gi] | ~req_in[gi] | squash),
      .sat  (sat[gi])
    );
  end

  assign any_sat = |sat;

  // Victim pick: the highest saturated index, so the lowest priority wins ties.
  always_comb begin
    sat_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sat[i]) begin
        sat_idx = i[VW-1:0];
      end
    end
  end

  // Keep the victim and everything below it in priority; reset forces pass-through.
  assign keep    = {NUM_REQ{1'b1}} << victim_q;
  assign req_out = (state_q == BOOST && !reset) ? (req_in & keep) : req_in;

  assign boost_active = (state_q == BOOST);
  assign boost_victim = victim_q;

  // Next-state, victim and cooldown logic; squash overrides everything.
  always_comb begin
    state_d  = state_q;
    victim_d = victim_q;
    cool_d   = cool_q;
    if (squash) begin
      state_d  = NORMAL;
      victim_d = '0;
      cool_d   = '0;
    end else begin
      case (state_q)
        NORMAL: begin
          if (any_sat) begin
            state_d  = BOOST;
            victim_d = sat_idx;
          end
        end
        BOOST: begin
          if (gnt_in[victim_q] || !req_in[victim_q]) begin
            state_d  = COOLDOWN;
            victim_d = '0;
            cool_d   = COOL_INIT;
          end
        end
        COOLDOWN: begin
          if (cool_q == 4'd0) begin
            state_d = NORMAL;
          end else begin
            cool_d = cool_q - 4'd1;
          end
        end
        default: begin
          state_d  = NORMAL;
          victim_d = '0;
          cool_d   = '0;
        end
      endcase
    end
  end

  // FSM state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= NORMAL;
      victim_q <= '0;
      cool_q   <= '0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
      cool_q   <= cool_d;
    end
  end

`ifdef CDB_STARVE_STATS_EN
  logic                          enter_boost;
  logic [NUM_REQ-1:0]            enter_vec;
  logic [NUM_REQ-1:0][15:0]      boost_count_q;
  logic [31:0]                   boost_cycles_q;

  assign enter_boost = (state_q == NORMAL) && (state_d == BOOST);
  assign enter_vec   = enter_boost ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << sat_idx) : '0;

  for (genvar gs = 0; gs < NUM_REQ; gs++) begin : g_stat
    // Saturating count of boosts granted to this requester.
    always_ff @(posedge clock) begin
      if (reset) begin
        boost_count_q[gs] <= '0;
      end else if (enter_vec[gs] && boost_count_q[gs] != 16'hFFFF) begin
        boost_count_q[gs] <= boost_count_q[gs] + 16'd1;
      end
    end
  end

  // Saturating count of cycles spent boosting.
  always_ff @(posedge clock) begin
    if (reset) begin
      boost_cycles_q <= '0;
    end else if (state_q == BOOST && boost_cycles_q != 32'hFFFF_FFFF) begin
      boost_cycles_q <= boost_cycles_q + 32'd1;
    end
  end

  assign boost_count  = boost_count_q;
  assign boost_cycles = boost_cycles_q;
`endif

endmodule

// File: tb/tb_cdb_starve_guard.sv
// Self-checking bench for cdb_starve_guard (default parameters: 6 requesters,
// limit 8, cooldown 2). Hand tables for the corner sequences, then random
// traffic against a behavioural reference model.
module tb_cdb_starve_guard;

  localparam int N    = 6;
  localparam int LIM  = 8;
  localparam int COOL = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       squash = 1'b0;
  logic [5:0] req_in = '0;
  logic [5:0] gnt_in = '0;
  logic [5:0] req_out;
  logic       boost_active;
  logic [2:0] boost_victim;
`ifdef CDB_STARVE_STATS_EN
  logic [5:0][15:0] boost_count;
  logic [31:0]      boost_cycles;
`endif

  always #5 clock = ~clock;

  cdb_starve_guard dut (
    .clock       (clock),
    .reset       (reset),
    .req_in      (req_in),
    .gnt_in      (gnt_in),
    .squash      (squash),
    .req_out     (req_out),
    .boost_active(boost_active),
    .boost_victim(boost_victim)
`ifdef CDB_STARVE_STATS_EN
    ,
    .boost_count (boost_count),
    .boost_cycles(boost_cycles)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain integers following the guard's rules.
  typedef enum int {M_NORMAL, M_BOOST, M_COOL} mstate_t;
  mstate_t    m_st = M_NORMAL;
  int         m_wait [N];
  int         m_vic = 0;
  int         m_cd  = 0;
  logic [5:0] m_ro;

  function automatic logic [5:0] model_ro(input logic [5:0] r, input logic rs);
    logic [5:0] o;
    o = r;
    if (m_st == M_BOOST && !rs) begin
      for (int j = 0; j < m_vic; j++) o[j] = 1'b0;
    end
    return o;
  endfunction

  task automatic model_step(input logic [5:0] r, input logic [5:0] g, input logic sq, input logic rs);
    mstate_t nst;
    int nv, ncd, best;
    if (rs || sq) begin
      m_st = M_NORMAL; m_vic = 0; m_cd = 0;
      for (int i = 0; i < N; i++) m_wait[i] = 0;
      return;
    end
    nst = m_st; nv = m_vic; ncd = m_cd;
    case (m_st)
      M_NORMAL: begin
        best = -1;
        for (int i = 0; i < N; i++) if (m_wait[i] == LIM) best = i;
        if (best >= 0) begin nst = M_BOOST; nv = best; end
      end
      M_BOOST: begin
        if (g[m_vic] || !r[m_vic]) begin nst = M_COOL; ncd = COOL; nv = 0; end
      end
      default: begin
        if (m_cd == 0) nst = M_NORMAL;
        else ncd = m_cd - 1;
      end
    endcase
    for (int i = 0; i < N; i++)
      m_wait[i] = (g[i] || !r[i]) ? 0 : ((m_wait[i] < LIM) ? m_wait[i] + 1 : LIM);
    m_st = nst; m_vic = nv; m_cd = ncd;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // One cycle: drive at negedge, check 1ns later, advance the model.
  // mode 0 = no check, 1 = explicit expectations, 2 = reference model.
  task automatic cyc(input logic [5:0] r, input logic [5:0] g, input logic sq, input logic rs,
                     input int mode, input logic [5:0] ero, input logic eact,
                     input logic [2:0] evic, input string tag);
    @(negedge clock);
    req_in = r; gnt_in = g; squash = sq; reset = rs;
    #1;
    m_ro = model_ro(r, rs);
    if (mode == 1) begin
      chk({tag, ".req_out"}, 32'(req_out), 32'(ero));
      chk({tag, ".boost_active"}, 32'(boost_active), 32'(eact));
      chk({tag, ".boost_victim"}, 32'(boost_victim), 32'(evic));
    end else if (mode == 2) begin
      chk({tag, ".req_out"}, 32'(req_out), 32'(m_ro));
      chk({tag, ".boost_active"}, 32'(boost_active), 32'(m_st == M_BOOST));
      chk({tag, ".boost_victim"}, 32'(boost_victim), 32'(m_vic));
    end
    model_step(r, g, sq, rs);
  endtask

  task automatic run_n(input int n, input logic [5:0] r, input logic [5:0] g,
                       input logic [5:0] ero, input logic eact, input logic [2:0] evic,
                       input string tag);
    for (int k = 0; k < n; k++) cyc(r, g, 1'b0, 1'b0, 1, ero, eact, evic, tag);
  endtask

  task automatic do_reset();
    cyc(6'b010110, 6'b0, 1'b0, 1'b1, 0, 6'b0, 1'b0, 3'd0, "rst");
    cyc(6'b010110, 6'b0, 1'b0, 1'b1, 1, 6'b010110, 1'b0, 3'd0, "rst");
  endtask

  typedef struct {
    logic [5:0] req;
    logic [5:0] gnt;
    logic [5:0] ro;
    logic       act;
    logic [2:0] vic;
  } vec_t;

  vec_t tie_tab [18];

  initial begin
    logic [5:0] r, g, prev_ro;
    logic       sq, rs;

    // Tie: 3 and 5 saturate together, 5 boosted first, 3 right after cooldown.
    for (int c = 0; c < 18; c++) tie_tab[c] = '{6'b101111, 6'b000111, 6'b101111, 1'b0, 3'd0};
    tie_tab[9]  = '{6'b101111, 6'b000111, 6'b100000, 1'b1, 3'd5};
    tie_tab[10] = '{6'b101111, 6'b100000, 6'b100000, 1'b1, 3'd5};
    tie_tab[15] = '{6'b101111, 6'b000111, 6'b101000, 1'b1, 3'd3};
    tie_tab[16] = '{6'b101111, 6'b001000, 6'b101000, 1'b1, 3'd3};

    do_reset();
    run_n(20, 6'b000101, 6'b000101, 6'b000101, 1'b0, 3'd0, "idle");

    do_reset();
    for (int c = 0; c < 18; c++)
      cyc(tie_tab[c].req, tie_tab[c].gnt, 1'b0, 1'b0, 1,
          tie_tab[c].ro, tie_tab[c].act, tie_tab[c].vic, "tie");

    // Withdrawal: victim drops its request mid-boost; mask holds in the exit cycle.
    do_reset();
    run_n(9, 6'b100011, 6'b000011, 6'b100011, 1'b0, 3'd0, "wd.pre");
    run_n(1, 6'b100011, 6'b000011, 6'b100000, 1'b1, 3'd5, "wd.boost");
    run_n(1, 6'b000011, 6'b000011, 6'b000000, 1'b1, 3'd5, "wd.drop");
    run_n(1, 6'b000011, 6'b000011, 6'b000011, 1'b0, 3'd0, "wd.cool");

    // Squash in the second boost cycle; counters restart from zero.
    do_reset();
    run_n(9, 6'b100001, 6'b000001, 6'b100001, 1'b0, 3'd0, "sq.pre");
    run_n(1, 6'b100001, 6'b000001, 6'b100000, 1'b1, 3'd5, "sq.boost");
    cyc(6'b100001, 6'b000000, 1'b1, 1'b0, 1, 6'b100000, 1'b1, 3'd5, "sq.squash");
    run_n(9, 6'b100000, 6'b000000, 6'b100000, 1'b0, 3'd0, "sq.after");
    run_n(1, 6'b100000, 6'b000000, 6'b100000, 1'b1, 3'd5, "sq.reboost");

    // Reset mid-boost: pass-through during reset, state cleared after.
    do_reset();
    run_n(9, 6'b100001, 6'b000001, 6'b100001, 1'b0, 3'd0, "rb.pre");
    run_n(1, 6'b100001, 6'b000001, 6'b100000, 1'b1, 3'd5, "rb.boost");
`ifdef CDB_STARVE_STATS_EN
    chk("rb.count_before", 32'(boost_count[5]), 32'd1);
`endif
    cyc(6'b100001, 6'b000001, 1'b0, 1'b1, 1, 6'b100001, 1'b1, 3'd5, "rb.reset");
    run_n(1, 6'b100001, 6'b000001, 6'b100001, 1'b0, 3'd0, "rb.after");
`ifdef CDB_STARVE_STATS_EN
    chk("rb.count_after", 32'(boost_count[5]), 32'd0);
`endif

    // Random traffic; grants come from a registered fixed-priority arbiter
    // that occasionally stalls.
    do_reset();
    r = '0;
    prev_ro = '0;
    for (int k = 0; k < 4000; k++) begin
      for (int b = 0; b < N; b++) if ($urandom_range(15) == 0) r[b] = ~r[b];
      if ($urandom_range(3) == 0) g = '0;
      else g = prev_ro & (~prev_ro + 6'd1);
      sq = ($urandom_range(149) == 0);
      rs = ($urandom_range(699) == 0);
      cyc(r, g, sq, rs, 2, 6'b0, 1'b0, 3'd0, "rand");
      prev_ro = rs ? 6'b0 : m_ro;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
